// File: rtl/clk_divider_prog_pkg.sv
// clk_div_pkg: shared constants and ratio helpers for clk_divider_prog
package clk_div_pkg;
  localparam int unsigned MIN_DIV = 2;
  localparam int CNT_W_DEF = 8;
  localparam int DEFAULT_DIV_DEF = 6;
  function automatic int unsigned clamp_div(int unsigned value);
    return value < MIN_DIV ? MIN_DIV : value;
  endfunction
  function automatic int unsigned half_div(int unsigned n);
    return n >> 1;
  endfunction
endpackage

// File: rtl/clk_divider_prog_if.sv
// clk_divider_prog_if: control/status bus of clk_divider_prog; master drives en/div_load/div_in, slave returns clk_out/tick/div_active/div_pending
interface clk_divider_prog_if import clk_div_pkg::*; #(parameter int CNT_W = CNT_W_DEF);
  logic en;
  logic div_load;
  logic [CNT_W-1:0] div_in;
  logic clk_out;
  logic tick;
  logic [CNT_W-1:0] div_active;
  logic div_pending;
  modport master(output en, div_load, div_in, input clk_out, tick, div_active, div_pending);
  modport slave(input en, div_load, div_in, output clk_out, tick, div_active, div_pending);
endinterface

// File: rtl/clk_divider_prog_duty_ext.sv
// clk_div_duty_ext: negedge stretch for 50% odd-ratio duty; ports clk, reset, i_clk_pos (posedge clk_out), i_odd (ratio is odd), o_clk_out
module clk_div_duty_ext (
  input  logic clk,
  input  logic reset,
  input  logic i_clk_pos,
  input  logic i_odd,
  output logic o_clk_out
);
  logic r_neg;
  always_ff @(negedge clk) r_neg <= reset ? 1'b0 : i_clk_pos;
  assign o_clk_out = i_odd ? (i_clk_pos | r_neg) : i_clk_pos;
endmodule

// File: rtl/clk_divider_prog.sv
// clk_divider_prog: runtime-programmable divider; ports clk, reset, bus (slave: en, div_load, div_in -> clk_out, tick, div_active, div_pending); define CLK_DIV_ODD_DUTY50_EN for 50% duty at odd ratios
module clk_divider_prog import clk_div_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input logic clk,
  input logic reset,
  clk_divider_prog_if.slave bus
);
  logic [CNT_W-1:0] r_cnt, r_div, r_pend;
  logic r_pending, r_clk, r_tick;
  logic w_bnd, w_clk_nxt, w_clk_out;
  logic [CNT_W-1:0] w_cnt_nxt, w_div_nxt, w_pend_in;
  always_comb begin
    w_bnd = bus.en && (r_cnt == r_div - CNT_W'(1));
    w_cnt_nxt = w_bnd ? '0 : r_cnt + CNT_W'(1);
    w_div_nxt = (w_bnd && r_pending) ? r_pend : r_div;
    w_clk_nxt = 32'(w_cnt_nxt) < half_div(32'(w_div_nxt));
    w_pend_in = CNT_W'(clamp_div(32'(bus.div_in)));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= CNT_W'(DEFAULT_DIV - 1);
      r_div <= CNT_W'(DEFAULT_DIV);
      r_pend <= '0;
      r_pending <= 1'b0;
      r_clk <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_bnd;
      if (bus.en) begin
        r_cnt <= w_cnt_nxt;
        r_div <= w_div_nxt;
        r_clk <= w_clk_nxt;
      end
      if (bus.div_load) begin
        r_pend <= w_pend_in;
        r_pending <= 1'b1;
      end else if (w_bnd) r_pending <= 1'b0;
    end
  end
`ifdef CLK_DIV_ODD_DUTY50_EN
  clk_div_duty_ext u_duty (
    .clk(clk),
    .reset(reset),
    .i_clk_pos(r_clk),
    .i_odd(r_div[0]),
    .o_clk_out(w_clk_out)
  );
`else
  assign w_clk_out = r_clk;
`endif
  assign bus.clk_out = w_clk_out;
  assign bus.tick = r_tick;
  assign bus.div_active = r_div;
  assign bus.div_pending = r_pending;
endmodule

// File: tb/tb_clk_divider_prog.sv
// tb_clk_divider_prog: self-checking bench for clk_divider_prog against a cycle-level reference model
module tb_clk_divider_prog;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int m_k, m_n, m_pend;
  bit m_pending, m_clk, m_tick, m_prev;
  clk_divider_prog_if #(.CNT_W(8)) bus();
  clk_divider_prog #(.CNT_W(8), .DEFAULT_DIV(6)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic bit exp_clk();
`ifdef CLK_DIV_ODD_DUTY50_EN
    return m_clk | ((m_n % 2 == 1) & m_prev);
`else
    return m_clk;
`endif
  endfunction
  task automatic cyc(input bit e, input bit l, input int d, input bit r = 1'b0);
    bus.en = e;
    bus.div_load = l;
    bus.div_in = 8'(d);
    reset = r;
    @(posedge clk);
    if (r) begin
      m_k = 5; m_n = 6; m_pend = 0; m_pending = 0; m_clk = 0; m_tick = 0; m_prev = 0;
    end else begin
      bit b;
      b = e && (m_k == m_n - 1);
      m_prev = m_clk;
      m_tick = b;
      if (e) begin
        if (b && m_pending) m_n = m_pend;
        m_k = b ? 0 : m_k + 1;
        m_clk = m_k < m_n / 2;
      end
      if (l) begin
        m_pend = d < 2 ? 2 : d;
        m_pending = 1;
      end else if (b) m_pending = 0;
    end
    #1;
  endtask
  task automatic test_reset();
    cyc(0, 0, 0, 1);
    cyc(1, 1, 3, 1);
    checks += 4;
    if (bus.clk_out !== 1'b0) begin errors++; $display("FAIL reset_clk_out: got %0b expected 0", bus.clk_out); end
    if (bus.tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %0b expected 0", bus.tick); end
    if (bus.div_active !== 8'd6) begin errors++; $display("FAIL reset_div_active: got %0d expected 6", bus.div_active); end
    if (bus.div_pending !== 1'b0) begin errors++; $display("FAIL reset_div_pending: got %0b expected 0", bus.div_pending); end
  endtask
  task automatic test_default();
    for (int i = 0; i < 18; i++) begin
      cyc(1, 0, 0);
      checks += 2;
      if (bus.tick !== 1'(i % 6 == 0)) begin errors++; $display("FAIL default_tick[%0d]: got %0b expected %0b", i, bus.tick, i % 6 == 0); end
      if (bus.clk_out !== 1'(i % 6 < 3)) begin errors++; $display("FAIL default_clk_out[%0d]: got %0b expected %0b", i, bus.clk_out, i % 6 < 3); end
    end
  endtask
  task automatic test_load_odd();
    int hi;
    bit got;
    got = 0;
`ifdef CLK_DIV_ODD_DUTY50_EN
    hi = 3;
`else
    hi = 2;
`endif
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 1, 5);
    checks += 2;
    if (bus.div_pending !== 1'b1) begin errors++; $display("FAIL odd_pending: got %0b expected 1", bus.div_pending); end
    if (bus.div_active !== 8'd6) begin errors++; $display("FAIL odd_active_before: got %0d expected 6", bus.div_active); end
    for (int i = 0; i < 10 && !got; i++) begin
      cyc(1, 0, 0);
      got = bus.tick;
      checks += 2;
      if (bus.clk_out !== exp_clk()) begin errors++; $display("FAIL odd_wait_clk_out: got %0b expected %0b", bus.clk_out, exp_clk()); end
      if (bus.div_pending !== m_pending) begin errors++; $display("FAIL odd_wait_pending: got %0b expected %0b", bus.div_pending, m_pending); end
    end
    checks += 3;
    if (!got) begin errors++; $display("FAIL odd_boundary_timeout: got no tick expected tick within 10 cycles"); end
    if (bus.div_active !== 8'd5) begin errors++; $display("FAIL odd_active_after: got %0d expected 5", bus.div_active); end
    if (bus.div_pending !== 1'b0) begin errors++; $display("FAIL odd_pending_after: got %0b expected 0", bus.div_pending); end
    for (int j = 0; j < 10; j++) begin
      if (j > 0) cyc(1, 0, 0);
      checks += 2;
      if (bus.tick !== 1'(j % 5 == 0)) begin errors++; $display("FAIL odd_tick[%0d]: got %0b expected %0b", j, bus.tick, j % 5 == 0); end
      if (bus.clk_out !== 1'(j % 5 < hi)) begin errors++; $display("FAIL odd_clk_out[%0d]: got %0b expected %0b", j, bus.clk_out, j % 5 < hi); end
    end
`ifdef CLK_DIV_ODD_DUTY50_EN
    begin
      longint t_rise, t_fall;
      t_rise = -1;
      t_fall = -1;
      fork
        begin
          @(posedge bus.clk_out);
          t_rise = $time;
          @(negedge bus.clk_out);
          t_fall = $time;
        end
        begin
          #500;
        end
      join_any
      disable fork;
      checks++;
      if (t_rise < 0 || t_fall < 0 || t_fall - t_rise != 25) begin errors++; $display("FAIL odd_high_time: got %0d expected 25", t_fall - t_rise); end
      cyc(0, 0, 0, 1);
    end
`endif
  endtask
  task automatic test_clamp();
    for (int d = 0; d < 2; d++) begin
      cyc(0, 0, 0, 1);
      cyc(1, 1, d);
      for (int i = 0; i < 6; i++) cyc(1, 0, 0);
      checks += 2;
      if (bus.div_active !== 8'd2) begin errors++; $display("FAIL clamp_active[%0d]: got %0d expected 2", d, bus.div_active); end
      if (bus.div_pending !== 1'b0) begin errors++; $display("FAIL clamp_pending[%0d]: got %0b expected 0", d, bus.div_pending); end
      for (int j = 0; j < 6; j++) begin
        if (j > 0) cyc(1, 0, 0);
        checks += 2;
        if (bus.tick !== 1'(j % 2 == 0)) begin errors++; $display("FAIL clamp_tick[%0d]: got %0b expected %0b", j, bus.tick, j % 2 == 0); end
        if (bus.clk_out !== 1'(j % 2 == 0)) begin errors++; $display("FAIL clamp_clk_out[%0d]: got %0b expected %0b", j, bus.clk_out, j % 2 == 0); end
      end
    end
  endtask
  task automatic test_boundary_load();
    int run, min_run;
    run = 0;
    min_run = 99;
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0);
    cyc(1, 1, 4);
    for (int i = 0; i < 10 && m_k != 5; i++) cyc(1, 0, 0);
    cyc(1, 1, 9);
    checks += 3;
    if (bus.tick !== 1'b1) begin errors++; $display("FAIL bload_tick: got %0b expected 1", bus.tick); end
    if (bus.div_active !== 8'd4) begin errors++; $display("FAIL bload_active4: got %0d expected 4", bus.div_active); end
    if (bus.div_pending !== 1'b1) begin errors++; $display("FAIL bload_pending: got %0b expected 1", bus.div_pending); end
    for (int j = 1; j <= 4; j++) cyc(1, 0, 0);
    checks += 3;
    if (bus.tick !== 1'b1) begin errors++; $display("FAIL bload_tick2: got %0b expected 1", bus.tick); end
    if (bus.div_active !== 8'd9) begin errors++; $display("FAIL bload_active9: got %0d expected 9", bus.div_active); end
    if (bus.div_pending !== 1'b0) begin errors++; $display("FAIL bload_pending2: got %0b expected 0", bus.div_pending); end
    for (int j = 0; j < 20; j++) begin
      if (bus.clk_out) run++;
      else begin
        if (run > 0 && run < min_run) min_run = run;
        run = 0;
      end
      cyc(1, 0, 0);
    end
    checks++;
    if (min_run < 2) begin errors++; $display("FAIL bload_runt: got high run %0d expected >= 2", min_run); end
  endtask
  task automatic test_enable_freeze();
    logic c;
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    c = bus.clk_out;
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 0);
      checks += 3;
      if (bus.clk_out !== c) begin errors++; $display("FAIL freeze_clk_out[%0d]: got %0b expected %0b", i, bus.clk_out, c); end
      if (bus.tick !== 1'b0) begin errors++; $display("FAIL freeze_tick[%0d]: got %0b expected 0", i, bus.tick); end
      if (bus.div_active !== 8'd6) begin errors++; $display("FAIL freeze_active[%0d]: got %0d expected 6", i, bus.div_active); end
    end
    for (int j = 0; j < 4; j++) begin
      cyc(1, 0, 0);
      checks += 2;
      if (bus.tick !== 1'(j == 3)) begin errors++; $display("FAIL resume_tick[%0d]: got %0b expected %0b", j, bus.tick, j == 3); end
      if (bus.clk_out !== 1'(j == 3)) begin errors++; $display("FAIL resume_clk_out[%0d]: got %0b expected %0b", j, bus.clk_out, j == 3); end
    end
  endtask
  task automatic test_reset_pending();
    cyc(1, 1, 10);
    cyc(1, 0, 0, 1);
    checks += 4;
    if (bus.div_active !== 8'd6) begin errors++; $display("FAIL rstp_active: got %0d expected 6", bus.div_active); end
    if (bus.div_pending !== 1'b0) begin errors++; $display("FAIL rstp_pending: got %0b expected 0", bus.div_pending); end
    if (bus.clk_out !== 1'b0) begin errors++; $display("FAIL rstp_clk_out: got %0b expected 0", bus.clk_out); end
    if (bus.tick !== 1'b0) begin errors++; $display("FAIL rstp_tick: got %0b expected 0", bus.tick); end
    for (int j = 0; j < 7; j++) begin
      cyc(1, 0, 0);
      checks += 2;
      if (bus.tick !== 1'(j % 6 == 0)) begin errors++; $display("FAIL rstp_tick[%0d]: got %0b expected %0b", j, bus.tick, j % 6 == 0); end
      if (bus.div_active !== 8'd6) begin errors++; $display("FAIL rstp_active[%0d]: got %0d expected 6", j, bus.div_active); end
    end
  endtask
  task automatic test_random();
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0, int'($urandom_range(0, 12)), $urandom_range(0, 149) == 0);
      checks += 4;
      if (bus.clk_out !== exp_clk()) begin errors++; $display("FAIL rand_clk_out[%0d]: got %0b expected %0b", i, bus.clk_out, exp_clk()); end
      if (bus.tick !== m_tick) begin errors++; $display("FAIL rand_tick[%0d]: got %0b expected %0b", i, bus.tick, m_tick); end
      if (bus.div_active !== 8'(m_n)) begin errors++; $display("FAIL rand_active[%0d]: got %0d expected %0d", i, bus.div_active, m_n); end
      if (bus.div_pending !== m_pending) begin errors++; $display("FAIL rand_pending[%0d]: got %0b expected %0b", i, bus.div_pending, m_pending); end
    end
  endtask
  initial begin
    bus.en = 1'b0;
    bus.div_load = 1'b0;
    bus.div_in = '0;
    test_reset();
    test_default();
    test_load_odd();
    test_clamp();
    test_boundary_load();
    test_enable_freeze();
    test_reset_pending();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/clk_divider_prog.md
Name: clk_divider_prog

Overview:
- Runtime-programmable integer clock divider; generalises the fixed divide-by-6 divider to any ratio N in [2, 2^CNT_W-1].
- Produces a registered divided clock-enable waveform, clk_out, and a one-cycle tick strobe at each rising edge of clk_out.
- Ratio changes are glitch-free: a new ratio takes effect only at a period boundary.
- Sits in the clocking/timebase area and feeds slow peripherals (UART baud, LED scan, sampling strobes).

Parameters:
- CNT_W, 8, width of the divide ratio and the internal counter.
- DEFAULT_DIV, 6, ratio active after reset; must satisfy 2 <= DEFAULT_DIV <= 2^CNT_W-1.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high; clock clk
- en  in  1  count enable; low freezes the counter and clk_out
- div_load  in  1  one-cycle request to load div_in
- div_in  in  CNT_W  requested divide ratio N
- clk_out  out  1  divided waveform, registered
- tick  out  1  one-cycle pulse on the clk edge where clk_out goes 0->1
- div_active  out  CNT_W  ratio currently in use
- div_pending  out  1  a loaded ratio is waiting for the period boundary

Behaviour:
- Reset values: cnt=DEFAULT_DIV-1, div_active=DEFAULT_DIV, pend_val=0, div_pending=0, clk_out=0, tick=0.
- Define N=div_active and H=N>>1 (floor).
- Counter, per posedge with en=1: if cnt==N-1, cnt<=0 (boundary); otherwise cnt<=cnt+1.
- Invariant: clk_out == (cnt < H) for the registered cnt value. It holds at reset because DEFAULT_DIV-1 >= H.
- Duty cycle:
  - Even N: clk_out is high for H cycles and low for H cycles.
  - Odd N: clk_out is high for H cycles and low for H+1 cycles, unless the optional feature is enabled.
- Startup: the first enabled edge after reset is a boundary. It gives cnt=0, clk_out=1, tick=1. Rising-edge latency from reset release with en=1 is 1 cycle.
- tick is 1 only on an enabled boundary edge, so period = N enabled cycles.
- en=0: cnt, clk_out, div_active and pend_val hold; tick=0. div_load is still accepted while en=0.
- Load: on div_load=1, the value is clamped and captured as pend_val <= (div_in<2 ? 2 : div_in), and div_pending <= 1.
  - A later div_load before the boundary overwrites pend_val ("last wins").
- Apply: on an enabled boundary edge with div_pending=1, div_active <= pend_val and div_pending <= 0.
  - On that same edge, clk_out is computed against the new H. Since cnt=0 < new H, clk_out=1 and no runt pulse occurs.
- Load on the boundary edge itself: the old pend_val (if any) is applied. The new value is captured, div_pending stays 1, and it applies at the next boundary.
- Reset during operation returns all state to reset values in the next cycle and discards any pending load.
- Width rule: all compares use CNT_W bits. N-1 cannot underflow because N >= 2.

Optional Feature:
- Macro CLK_DIV_ODD_DUTY50_EN.
- When defined: a negedge flop samples the posedge clk_out. For odd N only, the output is the OR of the posedge and negedge copies, giving a high time of H+0.5 cycles (exact 50% duty). For even N, the output is the posedge copy unchanged.
- The negedge flop resets synchronously to 0 on a falling clk edge while reset=1.
- tick is unaffected.
- When not defined: purely posedge logic; odd-N duty is H/N.

Decomposition:
- Package clk_div_pkg holds:
  - MIN_DIV = 2;
  - default CNT_W and DEFAULT_DIV constants;
  - a function clamp_div(value) returning max(value, MIN_DIV);
  - a function half_div(N) returning N>>1.
- Sub-module clk_div_duty_ext (negedge stretch plus odd/even select) is instantiated only under CLK_DIV_ODD_DUTY50_EN. Counter and load logic stay in the top level.

Test Plan:
- Reset, then en=1 with DEFAULT_DIV=6 -> tick every 6 cycles; clk_out is 1 for 3 cycles and 0 for 3; first tick 1 cycle after reset release.
- div_load with div_in=5 mid-period -> div_pending=1 until the next boundary; then period=5, clk_out high 2 cycles and low 3 cycles (macro off), or high 2.5 cycles (macro on, checked by time measurement).
- div_in=0 and, in a separate run, div_in=1 -> div_active=2; clk_out toggles every cycle; tick every 2 cycles.
- div_load=1 exactly on the boundary edge with div_in=9, while pend_val=4 is waiting -> next period uses 4 and the following period uses 9; no clk_out pulse shorter than the smaller high time.
- en low for 7 cycles mid-period with N=6, cnt=2 -> cnt, clk_out and div_active frozen; tick=0; count resumes from cnt=2 with no phase loss.
- Assert reset during a pending load (div_in=10) -> after reset: div_active=6, div_pending=0, clk_out=0, cnt=5.
